dmem_ctrl: RTL

- Parametrised data-memory subsystem for the next-generation CPU top; replaces the fixed-map, word-only, zero-latency data memory hookup.
- Translates CPU byte addresses against a configurable base, supports byte/half/word loads and stores with sign/zero extension, and models configurable wait states behind a req/ready handshake.
- Sits between the CPU's ALU-address/store-data outputs and the load-data input; the CPU stalls on busy.

---
 rtl/dmem_ctrl_if.sv | 25 ++
 rtl/dmem_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl_if.sv
// Request/response bus between the CPU load/store path and dmem_ctrl.
// The CPU holds request fields stable only until the accept edge.
`timescale 1ns/1ps
interface dmem_ctrl_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        err;

    modport master (
        output req, we, size, sign_ext, addr, wdata,
        input  rdata, ready, busy, err
    );

    modport slave (
        input  req, we, size, sign_ext, addr, wdata,
        output rdata, ready, busy, err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Data memory with base-relative mapping, sub-word access and wait states.
// Define DMEM_ALIGN_CHECK_EN to fault misaligned half/word accesses.
`timescale 1ns/1ps
module dmem_ctrl #(
    parameter logic [31:0] DATA_BASE   = 32'h1001_0000,
    parameter int unsigned ADDR_W      = 11,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic      clk_in,
    input  logic      reset,
    dmem_ctrl_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [3:0]  WS    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic        sx_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        ready_q;
    logic        busy_q;
    logic        err_q;

    logic [31:0] mem_q [DEPTH];

    logic [31:0]       offset;
    logic [ADDR_W-1:0] idx;
    logic              oor;
    logic              misal;
    logic              fault;
    logic              done;
    logic              is_byte;
    logic              is_half;
    logic [31:0]       word;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [31:0]       ld_val;
    logic [31:0]       lane_mask;
    logic [31:0]       lane_data;
    logic [31:0]       st_word;

    // Addresses below the base wrap to huge offsets and land out of range.
    assign offset = addr_q - DATA_BASE;
    assign idx    = offset[ADDR_W+1:2];
    assign oor    = |(offset >> (ADDR_W + 2));

`ifdef DMEM_ALIGN_CHECK_EN
    assign misal = ((size_q == 2'b01) & addr_q[0]) |
                   ((size_q == 2'b10) & (|addr_q[1:0]));
`else
    assign misal = 1'b0;
`endif

    assign fault   = (size_q == 2'b11) | oor | misal;
    assign done    = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign is_byte = (size_q == 2'b00);
    assign is_half = (size_q == 2'b01);
    assign word    = mem_q[idx];
    assign byte_v  = word[{addr_q[1:0], 3'b000} +: 8];
    assign half_v  = word[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        ld_val    = word;
        lane_mask = 32'hFFFF_FFFF;
        lane_data = wdata_q;
        unique case (1'b1)
            is_byte: begin
                ld_val    = {{24{sx_q & byte_v[7]}}, byte_v};
                lane_mask = 32'h0000_00FF << {addr_q[1:0], 3'b000};
                lane_data = {24'b0, wdata_q[7:0]} << {addr_q[1:0], 3'b000};
            end
            is_half: begin
                ld_val    = {{16{sx_q & half_v[15]}}, half_v};
                lane_mask = 32'h0000_FFFF << {addr_q[1], 4'b0000};
                lane_data = {16'b0, wdata_q[15:0]} << {addr_q[1], 4'b0000};
            end
            default: begin
                ld_val    = word;
                lane_mask = 32'hFFFF_FFFF;
                lane_data = wdata_q;
            end
        endcase
    end

    assign st_word = (word & ~lane_mask) | (lane_data & lane_mask);

    // The array has no reset; a store only lands on the completion edge.
    always_ff @(posedge clk_in) begin
        if (done && we_q && !fault) begin
            mem_q[idx] <= st_word;
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            sx_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            unique case (state_q)
                S_IDLE, S_RESP: begin
                    if (bus.req) begin
                        we_q    <= bus.we;
                        sx_q    <= bus.sign_ext;
                        size_q  <= bus.size;
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        cnt_q   <= WS;
                        busy_q  <= 1'b1;
                        state_q <= S_WAIT;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        err_q   <= fault;
                        state_q <= S_RESP;
                        if (fault) begin
                            rdata_q <= 32'd0;
                        end else if (!we_q) begin
                            rdata_q <= ld_val;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.err   = err_q;
endmodule
